// File: rtl/icache_linefill_responder_pkg.sv
// Shared types and constants for the icache linefill responder.
// Opcode, beat geometry and tracking-table entry layout.
package icache_linefill_responder_pkg;

  localparam int LF_ADDR_W  = 32;
  localparam int LF_ENTRY_W = 3;
  localparam int LF_LINE_W  = 512;
  localparam int LF_BEAT_W  = 256;
  localparam int LF_OPC_W   = 4;

  localparam int LF_BEAT_NUM = LF_LINE_W / LF_BEAT_W;

  localparam logic [LF_OPC_W-1:0] LF_DONE_OPCODE = 4'h6;

  typedef struct packed {
    logic [LF_ADDR_W-1:0]  addr;
    logic [LF_ENTRY_W-1:0] entry_id;
  } lf_entry_t;

  typedef enum logic [1:0] {
    LF_IDLE = 2'd0,
    LF_SEND = 2'd1,
    LF_RESP = 2'd2
  } lf_state_e;

endpackage

// File: rtl/icache_lf_beat_sender.sv
// Line buffer and beat sequencer: latches one memory line,
// streams it as rxdat beats, then issues one txrsp completion.
module icache_lf_beat_sender
  import icache_linefill_responder_pkg::*;
#(
  parameter int ENTRY_W = 3,
  parameter int LINE_W  = 512,
  parameter int BEAT_W  = 256,
  parameter int OPC_W   = 4,
  localparam int BEAT_NUM = LINE_W / BEAT_W,
  localparam int BEAT_IW  = $clog2(BEAT_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_rsp_vld,
  output logic               mem_rsp_rdy,
  input  logic [LINE_W-1:0]  mem_rsp_data,
  input  logic [ENTRY_W-1:0] line_id,
  output logic               rxdat_vld,
  input  logic               rxdat_rdy,
  output logic [BEAT_W-1:0]  rxdat_data,
  output logic [ENTRY_W-1:0] rxdat_entry_id,
  output logic [BEAT_IW-1:0] rxdat_beat,
  output logic               rxdat_last,
  output logic               txrsp_vld,
  input  logic               txrsp_rdy,
  output logic [OPC_W-1:0]   txrsp_opcode,
  output logic               retire
);

  localparam logic [BEAT_IW-1:0] LAST_BEAT =
    BEAT_IW'(BEAT_NUM - 1);

  lf_state_e          state_q, state_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [ENTRY_W-1:0] id_q, id_d;
  logic [BEAT_IW-1:0] beat_q, beat_d;
  logic               last_q, last_d;
  logic               rx_vld_q, rx_vld_d;
  logic               tx_vld_q, tx_vld_d;
  logic               rsp_rdy_q, rsp_rdy_d;
  logic [OPC_W-1:0]   opc_q, opc_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    id_d    = id_q;
    beat_d  = beat_q;
    unique case (state_q)
      LF_IDLE: begin
        if (mem_rsp_vld) begin
          state_d = LF_SEND;
          line_d  = mem_rsp_data;
          id_d    = line_id;
          beat_d  = '0;
        end
      end
      LF_SEND: begin
        if (rxdat_rdy) begin
          if (beat_q == LAST_BEAT) begin
            state_d = LF_RESP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      LF_RESP: begin
        if (txrsp_rdy) state_d = LF_IDLE;
      end
      default: state_d = LF_IDLE;
    endcase
    rx_vld_d  = (state_d == LF_SEND);
    tx_vld_d  = (state_d == LF_RESP);
    rsp_rdy_d = (state_d == LF_IDLE);
    last_d    = rx_vld_d && (beat_d == LAST_BEAT);
    opc_d     = tx_vld_d ? OPC_W'(LF_DONE_OPCODE) : '0;
  end

  // FSM state, line buffer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LF_IDLE;
      line_q    <= '0;
      id_q      <= '0;
      beat_q    <= '0;
      last_q    <= 1'b0;
      rx_vld_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      rsp_rdy_q <= 1'b1;
      opc_q     <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      id_q      <= id_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      rx_vld_q  <= rx_vld_d;
      tx_vld_q  <= tx_vld_d;
      rsp_rdy_q <= rsp_rdy_d;
      opc_q     <= opc_d;
    end
  end

  assign mem_rsp_rdy    = rsp_rdy_q;
  assign rxdat_vld      = rx_vld_q;
  assign rxdat_data     = line_q[beat_q*BEAT_W +: BEAT_W];
  assign rxdat_entry_id = id_q;
  assign rxdat_beat     = beat_q;
  assign rxdat_last     = last_q;
  assign txrsp_vld      = tx_vld_q;
  assign txrsp_opcode   = opc_q;
  assign retire         = tx_vld_q & txrsp_rdy;

endmodule

// File: rtl/icache_linefill_responder.sv
// Linefill responder: in-order request table feeding memory reads,
// with line return delegated to the beat sender.
module icache_linefill_responder
  import icache_linefill_responder_pkg::*;
#(
  parameter int ADDR_W  = LF_ADDR_W,
  parameter int ENTRY_W = LF_ENTRY_W,
  parameter int LINE_W  = LF_LINE_W,
  parameter int BEAT_W  = LF_BEAT_W,
  parameter int OPC_W   = LF_OPC_W,
  parameter int DEPTH   = 4,
  localparam int BEAT_NUM = LINE_W / BEAT_W,
  localparam int BEAT_IW  = $clog2(BEAT_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [ENTRY_W-1:0] req_entry_id,
  output logic               mem_req_vld,
  input  logic               mem_req_rdy,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_vld,
  output logic               mem_rsp_rdy,
  input  logic [LINE_W-1:0]  mem_rsp_data,
  output logic               rxdat_vld,
  input  logic               rxdat_rdy,
  output logic [BEAT_W-1:0]  rxdat_data,
  output logic [ENTRY_W-1:0] rxdat_entry_id,
  output logic [BEAT_IW-1:0] rxdat_beat,
  output logic               rxdat_last,
  output logic               txrsp_vld,
  input  logic               txrsp_rdy,
  output logic [OPC_W-1:0]   txrsp_opcode,
  output logic               err_dup_id
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'(LINE_W / 8 - 1);

  logic [DEPTH-1:0][ADDR_W-1:0]  tbl_addr_q, tbl_addr_d;
  logic [DEPTH-1:0][ENTRY_W-1:0] tbl_id_q, tbl_id_d;
  logic [DEPTH-1:0]              tbl_vld_q, tbl_vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] iss_ptr_q, iss_ptr_d;
  logic [PTR_W-1:0] ret_ptr_q, ret_ptr_d;
  logic             err_dup_q, err_dup_d;

  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] wr_idx, iss_idx, ret_idx;
  logic             accept, issue, retire, dup_hit;

  assign wr_idx  = wr_ptr_q[IDX_W-1:0];
  assign iss_idx = iss_ptr_q[IDX_W-1:0];
  assign ret_idx = ret_ptr_q[IDX_W-1:0];
  assign count   = wr_ptr_q - ret_ptr_q;

  assign req_rdy      = (count != PTR_W'(DEPTH));
  assign accept       = req_vld & req_rdy;
  assign mem_req_vld  = (iss_ptr_q != wr_ptr_q);
  assign mem_req_addr = tbl_addr_q[iss_idx] & ~OFF_MASK;
  assign issue        = mem_req_vld & mem_req_rdy;
  assign err_dup_id   = err_dup_q;

  // Incoming id collides with any still-outstanding entry
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_vld_q[i] && (tbl_id_q[i] == req_entry_id)) begin
        dup_hit = 1'b1;
      end
    end
  end

  // Table writes, pointer advance and sticky duplicate flag
  always_comb begin
    tbl_addr_d = tbl_addr_q;
    tbl_id_d   = tbl_id_q;
    tbl_vld_d  = tbl_vld_q;
    wr_ptr_d   = wr_ptr_q;
    iss_ptr_d  = iss_ptr_q;
    ret_ptr_d  = ret_ptr_q;
    err_dup_d  = err_dup_q;
    if (accept) begin
      tbl_addr_d[wr_idx] = req_addr;
      tbl_id_d[wr_idx]   = req_entry_id;
      tbl_vld_d[wr_idx]  = 1'b1;
      wr_ptr_d           = wr_ptr_q + 1'b1;
      if (dup_hit) err_dup_d = 1'b1;
    end
    if (issue) iss_ptr_d = iss_ptr_q + 1'b1;
    if (retire) begin
      tbl_vld_d[ret_idx] = 1'b0;
      ret_ptr_d          = ret_ptr_q + 1'b1;
    end
  end

  // Tracking table and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_addr_q <= '0;
      tbl_id_q   <= '0;
      tbl_vld_q  <= '0;
      wr_ptr_q   <= '0;
      iss_ptr_q  <= '0;
      ret_ptr_q  <= '0;
      err_dup_q  <= 1'b0;
    end else begin
      tbl_addr_q <= tbl_addr_d;
      tbl_id_q   <= tbl_id_d;
      tbl_vld_q  <= tbl_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      iss_ptr_q  <= iss_ptr_d;
      ret_ptr_q  <= ret_ptr_d;
      err_dup_q  <= err_dup_d;
    end
  end

  icache_lf_beat_sender #(
    .ENTRY_W (ENTRY_W),
    .LINE_W  (LINE_W),
    .BEAT_W  (BEAT_W),
    .OPC_W   (OPC_W)
  ) u_sender (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_rsp_vld    (mem_rsp_vld),
    .mem_rsp_rdy    (mem_rsp_rdy),
    .mem_rsp_data   (mem_rsp_data),
    .line_id        (tbl_id_q[ret_idx]),
    .rxdat_vld      (rxdat_vld),
    .rxdat_rdy      (rxdat_rdy),
    .rxdat_data     (rxdat_data),
    .rxdat_entry_id (rxdat_entry_id),
    .rxdat_beat     (rxdat_beat),
    .rxdat_last     (rxdat_last),
    .txrsp_vld      (txrsp_vld),
    .txrsp_rdy      (txrsp_rdy),
    .txrsp_opcode   (txrsp_opcode),
    .retire         (retire)
  );

  // Memory data must belong to an issued, unretired line
  a_rsp_has_owner: assert property (
    @(posedge clk) disable iff (!rst_n)
    mem_rsp_vld |-> (iss_ptr_q != ret_ptr_q)
  );

endmodule

// File: tb/tb_icache_linefill_responder.sv
// Directed bench for the linefill responder with a memory
// model and an in-order scoreboard of expected lines.
module tb_icache_linefill_responder;
  import icache_linefill_responder_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_vld;
  logic         req_rdy;
  logic [31:0]  req_addr;
  logic [2:0]   req_entry_id;
  logic         mem_req_vld;
  logic         mem_req_rdy;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_vld;
  logic         mem_rsp_rdy;
  logic [511:0] mem_rsp_data;
  logic         rxdat_vld;
  logic         rxdat_rdy;
  logic [255:0] rxdat_data;
  logic [2:0]   rxdat_entry_id;
  logic [0:0]   rxdat_beat;
  logic         rxdat_last;
  logic         txrsp_vld;
  logic         txrsp_rdy;
  logic [3:0]   txrsp_opcode;
  logic         err_dup_id;

  always #5 clk = ~clk;

  icache_linefill_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_addr       (req_addr),
    .req_entry_id   (req_entry_id),
    .mem_req_vld    (mem_req_vld),
    .mem_req_rdy    (mem_req_rdy),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_vld    (mem_rsp_vld),
    .mem_rsp_rdy    (mem_rsp_rdy),
    .mem_rsp_data   (mem_rsp_data),
    .rxdat_vld      (rxdat_vld),
    .rxdat_rdy      (rxdat_rdy),
    .rxdat_data     (rxdat_data),
    .rxdat_entry_id (rxdat_entry_id),
    .rxdat_beat     (rxdat_beat),
    .rxdat_last     (rxdat_last),
    .txrsp_vld      (txrsp_vld),
    .txrsp_rdy      (txrsp_rdy),
    .txrsp_opcode   (txrsp_opcode),
    .err_dup_id     (err_dup_id)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  id;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] issued_q[$];

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  int ncompl = 0;
  int exp_beat = 0;
  int stall_cnt = 0;
  int t_mem, t_b0, t_last, t_tx;
  int mem_hs_cnt = 0;
  int mem_pop_cnt = 0;
  int acc_ncompl = 0;
  bit mem_en = 1'b0;
  bit await_tx = 1'b0;
  bit prev_stall = 1'b0;
  logic [255:0] prev_data;
  logic [4:0]   prev_meta;
  logic [511:0] mon_line;

  function automatic logic [511:0] line_of(input logic [31:0] a);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) begin
      l[i*32 +: 32] = a ^ (32'h0101_0101 * 32'(i)) ^ 32'hC3A5_0000;
    end
    return l;
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor and scoreboard, sampled away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_addr_q.delete();
      exp_beat = 0;
      await_tx = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (mem_req_vld && mem_req_rdy) begin
        if (exp_addr_q.size() == 0) chk("mem_req_spurious", 1, 0);
        else chk("mem_req_addr", mem_req_addr, exp_addr_q.pop_front());
        issued_q.push_back(mem_req_addr);
      end
      if (mem_rsp_vld && mem_rsp_rdy) begin
        mem_hs_cnt++;
        t_mem = cyc;
      end
      if (prev_stall) begin
        chk("hold_vld", rxdat_vld, 1);
        chk("hold_data", rxdat_data, prev_data);
        chk("hold_meta",
            {rxdat_entry_id, rxdat_beat, rxdat_last}, prev_meta);
      end
      prev_stall = rxdat_vld && !rxdat_rdy;
      if (prev_stall) stall_cnt++;
      prev_data = rxdat_data;
      prev_meta = {rxdat_entry_id, rxdat_beat, rxdat_last};
      if (rxdat_vld && rxdat_rdy) begin
        if (exp_q.size() == 0 || await_tx) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          mon_line = line_of(exp_q[0].addr & ~32'h3F);
          chk("beat_data", rxdat_data, mon_line[exp_beat*256 +: 256]);
          chk("beat_meta",
              {rxdat_entry_id, rxdat_beat, rxdat_last},
              {exp_q[0].id, exp_beat[0], (exp_beat == 1)});
          if (exp_beat == 0) t_b0 = cyc;
          if (exp_beat == 1) begin
            t_last = cyc;
            await_tx = 1'b1;
            exp_beat = 0;
          end else begin
            exp_beat++;
          end
        end
      end
      if (txrsp_vld && txrsp_rdy) begin
        chk("txrsp_order", await_tx, 1);
        chk("txrsp_opcode", txrsp_opcode, LF_DONE_OPCODE);
        if (exp_q.size() != 0) exp_q.delete(0);
        await_tx = 1'b0;
        ncompl++;
        t_tx = cyc;
      end
    end
  end

  // Memory model: returns issued lines in order
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      issued_q.delete();
      mem_pop_cnt = mem_hs_cnt;
    end else begin
      while (mem_pop_cnt < mem_hs_cnt) begin
        issued_q.delete(0);
        mem_pop_cnt++;
      end
    end
    mem_rsp_vld = rst_n && mem_en && (issued_q.size() != 0);
    mem_rsp_data = mem_rsp_vld ? line_of(issued_q[0]) : '0;
  end

  task automatic send_req(input logic [31:0] a, input logic [2:0] id);
    int n = 0;
    bit ok = 1'b0;
    exp_t e;
    req_vld = 1'b1;
    req_addr = a;
    req_entry_id = id;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (req_rdy) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("req_accept_timeout", ok, 1);
    if (ok) begin
      acc_ncompl = ncompl;
      e.addr = a;
      e.id = id;
      exp_q.push_back(e);
      exp_addr_q.push_back(a & ~32'h3F);
      @(posedge clk);
      #1;
    end
    req_vld = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    req_vld = 1'b0;
    req_addr = '0;
    req_entry_id = '0;
    mem_req_rdy = 1'b1;
    rxdat_rdy = 1'b1;
    txrsp_rdy = 1'b1;
    mem_rsp_vld = 1'b0;
    mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_mem_rsp_rdy", mem_rsp_rdy, 1);
    chk("rst_valids", {mem_req_vld, rxdat_vld, txrsp_vld}, 0);
    chk("rst_err_dup", err_dup_id, 0);
    chk("rst_data", rxdat_data, 0);
    chk("rst_mem_addr", mem_req_addr, 0);
    @(posedge clk);
    #1;

    // single line, unaligned address, earliest timing
    mem_en = 1'b1;
    send_req(32'h1000_0047, 3'd2);
    wait_done(100, "t1_done");
    chk("t1_beat0_lat", t_b0 - t_mem, 1);
    chk("t1_last_lat", t_last - t_mem, 2);
    chk("t1_txrsp_lat", t_tx - t_mem, 3);
    chk("t1_ncompl", ncompl, 1);

    // fill table with memory stalled, 5th waits for a retire
    base = ncompl;
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_req(32'h2000_0000 + 32'(i * 64 + i), 3'(i));
    end
    @(negedge clk);
    chk("t2_full_rdy", req_rdy, 0);
    chk("t2_mem_req_vld", mem_req_vld, 1);
    @(posedge clk);
    #1;
    req_vld = 1'b1;
    req_addr = 32'h2000_0100;
    req_entry_id = 3'd4;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t2_stall5", req_rdy, 0);
    @(posedge clk);
    #1;
    mem_req_rdy = 1'b1;
    send_req(32'h2000_0100, 3'd4);
    chk("t2_accept_after_retire", acc_ncompl - base, 1);
    wait_done(400, "t2_done");
    chk("t2_ncompl", ncompl - base, 5);

    // rxdat_rdy toggling every cycle
    stall_cnt = 0;
    send_req(32'h3000_0004, 3'd7);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      rxdat_rdy = ~rxdat_rdy;
      n++;
    end
    rxdat_rdy = 1'b1;
    chk("t3_done", exp_q.size(), 0);
    chk("t3_saw_stall", (stall_cnt > 0), 1);

    // memory data back-pressured while a line is sending
    rxdat_rdy = 1'b0;
    send_req(32'h4000_0000, 3'd5);
    send_req(32'h4000_0040, 3'd6);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t4_sending", rxdat_vld, 1);
    chk("t4_mem_vld_held", mem_rsp_vld, 1);
    chk("t4_mem_rsp_rdy", mem_rsp_rdy, 0);
    @(posedge clk);
    #1;
    rxdat_rdy = 1'b1;
    wait_done(100, "t4_done");

    // duplicate id while first is outstanding
    chk("t5_no_dup_yet", err_dup_id, 0);
    rxdat_rdy = 1'b0;
    send_req(32'h5000_0000, 3'd1);
    send_req(32'h5000_0100, 3'd1);
    @(negedge clk);
    chk("t5_dup_set", err_dup_id, 1);
    @(posedge clk);
    #1;
    rxdat_rdy = 1'b1;
    wait_done(100, "t5_done");
    chk("t5_dup_sticky", err_dup_id, 1);

    // reset in the middle of a line
    send_req(32'h6000_0080, 3'd3);
    n = 0;
    while (exp_beat != 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_beat0_seen", exp_beat, 1);
    @(posedge clk);
    #1;
    rxdat_rdy = 1'b0;
    #2;
    mem_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valids", {mem_req_vld, rxdat_vld, txrsp_vld}, 0);
    chk("t6_rst_req_rdy", req_rdy, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rxdat_rdy = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_quiet", {mem_req_vld, rxdat_vld, txrsp_vld}, 0);
    chk("t6_req_rdy", req_rdy, 1);
    chk("t6_dup_cleared", err_dup_id, 0);
    @(posedge clk);
    #1;
    mem_en = 1'b1;
    base = ncompl;
    send_req(32'h7000_0000, 3'd3);
    wait_done(100, "t6_recover");
    chk("t6_recover_cnt", ncompl - base, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
